// File: rtl/fifo_burst_reader.sv
// Pops exactly BURST_LEN words from a 1-cycle-latency FIFO and streams them on valid/ready,
// tagging the final word with outLast. A 2-entry skid buffer hides the FIFO read latency.
module fifo_burst_reader #(
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifoIsEmpty,
  input  logic [FIFO_WIDTH-1:0] fifoDataOut,
  output logic                  fifoReadEn,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [FIFO_WIDTH-1:0] outData,
  output logic                  outLast,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [CNT_WIDTH-1:0] BURST_CNT = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(BURST_LEN - 1);

  stateT                 stateReg;
  stateT                 stateNext;
  logic [CNT_WIDTH-1:0]  issueCnt;
  logic [CNT_WIDTH-1:0]  sendCnt;
  logic                  inflight;
  logic [1:0]            occ;
  logic                  headPtr;
  logic                  tailPtr;
  logic [FIFO_WIDTH-1:0] skidMem [2];
  logic                  accept;
  logic [2:0]            pending;

  assign outValid = (occ != 2'd0);
  assign accept   = outValid && outReady;
  assign outData  = outValid ? skidMem[headPtr] : '0;
  assign outLast  = outValid && (sendCnt == LAST_IDX);

  // Words still owed to the buffer after this cycle; a new pop is only safe if a slot remains.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, accept};
  assign fifoReadEn = !rst && (stateReg == RUN) && !fifoIsEmpty &&
                      (issueCnt < BURST_CNT) && (pending < 3'd2);

  always_comb begin
    stateNext = stateReg;
    busy      = 1'b0;
    done      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (accept && outLast) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      issueCnt <= '0;
      sendCnt  <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      headPtr  <= 1'b0;
      tailPtr  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      inflight <= fifoReadEn;
      // Counters clear on the way back to IDLE so the next burst starts from zero.
      if (stateReg == DONE) begin
        issueCnt <= '0;
        sendCnt  <= '0;
      end else begin
        if (fifoReadEn) issueCnt <= issueCnt + CNT_WIDTH'(1);
        if (accept)     sendCnt  <= sendCnt + CNT_WIDTH'(1);
      end
      if (inflight) tailPtr <= ~tailPtr;
      if (accept)   headPtr <= ~headPtr;
      occ <= occ + {1'b0, inflight} - {1'b0, accept};
    end
  end

  // The word returned by last cycle's pop lands at the buffer tail.
  always_ff @(posedge clk) begin
    if (inflight) skidMem[tailPtr] <= fifoDataOut;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed-sequence bench with randomized data/handshake, checked against a queue-based model
// of the attached FIFO and of the expected burst stream.
module tb_fifo_burst_reader;

  localparam int W  = 8;
  localparam int BL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         fifoIsEmpty;
  logic [W-1:0] fifoDataOut = '0;
  logic         fifoReadEn;
  logic         outValid;
  logic         outReady;
  logic [W-1:0] outData;
  logic         outLast;
  logic         busy;
  logic         done;

  logic         start1;
  logic         empty1 = 1'b0;
  logic [W-1:0] data1 = '0;
  logic         readEn1;
  logic         valid1;
  logic         ready1 = 1'b1;
  logic [W-1:0] outData1;
  logic         last1;
  logic         busy1;
  logic         done1;

  always #5 clk = ~clk;

  fifo_burst_reader #(.FIFO_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .start(start), .fifoIsEmpty(fifoIsEmpty), .fifoDataOut(fifoDataOut),
    .fifoReadEn(fifoReadEn), .outValid(outValid), .outReady(outReady), .outData(outData),
    .outLast(outLast), .busy(busy), .done(done)
  );

  fifo_burst_reader #(.FIFO_WIDTH(W), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .fifoIsEmpty(empty1), .fifoDataOut(data1),
    .fifoReadEn(readEn1), .outValid(valid1), .outReady(ready1), .outData(outData1),
    .outLast(last1), .busy(busy1), .done(done1)
  );

  int testsRun = 0;
  int testsFailed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Attached FIFO model: bench pushes, DUT pops; data appears the cycle after readEn.
  logic [W-1:0] fifoMem [256];
  logic [7:0]   wrIdx = 8'd0;
  logic [7:0]   rdIdx = 8'd0;
  int           totalPops = 0;
  int           cyc = 0;
  int           pops1 = 0;
  logic [W-1:0] popped [$];

  assign fifoIsEmpty = (rdIdx == wrIdx);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifoReadEn) begin
      fifoDataOut <= fifoMem[rdIdx];
      popped.push_back(fifoMem[rdIdx]);
      rdIdx     <= rdIdx + 8'd1;
      totalPops <= totalPops + 1;
    end
    if (readEn1) begin
      data1 <= 8'h5A ^ 8'(pops1);
      pops1 <= pops1 + 1;
    end
  end

  // Stream monitor: every accepted word must be the oldest popped-but-unsent word.
  logic [W-1:0] acc [$];
  logic         accLast [$];
  int           accCyc [$];
  int           burstAcc = 0;
  logic         prevStall = 1'b0;
  logic         prevLastAcc = 1'b0;
  logic [W-1:0] prevData = '0;
  logic         prevLast = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      popped.delete();
      burstAcc    = 0;
      prevStall   = 1'b0;
      prevLastAcc = 1'b0;
    end else begin
      check("donePulse", 32'(done), 32'(prevLastAcc));
      if (fifoReadEn) check("readEnWhileEmpty", 32'(fifoIsEmpty), 32'd0);
      check("outstandingLe2", 32'(popped.size() <= 2), 32'd1);
      if (prevStall) begin
        check("stallValid", 32'(outValid), 32'd1);
        check("stallData", 32'(outData), 32'(prevData));
        check("stallLast", 32'(outLast), 32'(prevLast));
      end
      prevLastAcc = 1'b0;
      if (outValid && outReady) begin
        if (popped.size() == 0) begin
          check("acceptWithoutPop", 32'(popped.size()), 32'd1);
        end else begin
          check("acceptData", 32'(outData), 32'(popped.pop_front()));
        end
        check("acceptLast", 32'(outLast), 32'(burstAcc == BL - 1));
        acc.push_back(outData);
        accLast.push_back(outLast);
        accCyc.push_back(cyc);
        if (burstAcc == BL - 1) begin
          burstAcc    = 0;
          prevLastAcc = 1'b1;
        end else begin
          burstAcc++;
        end
      end else if (!outValid) begin
        check("lastWithoutValid", 32'(outLast), 32'd0);
      end
      prevStall = outValid && !outReady;
      prevData  = outData;
      prevLast  = outLast;
    end
  end

  task automatic push(input logic [W-1:0] v);
    fifoMem[wrIdx] = v;
    wrIdx = wrIdx + 8'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(output int startCyc);
    start = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // readyMode: 0 hold, 1 toggle each cycle, 2 random
  task automatic waitDone(input int budget, input int readyMode, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      if (readyMode == 1) outReady = !outReady;
      else if (readyMode == 2) outReady = 1'($urandom);
      n++;
    end
    check({tag, "_doneSeen"}, 32'(done), 32'd1);
  endtask

  task automatic checkBurst(input int base, input logic [7:0] expBase, input string tag);
    logic [7:0] idx;
    check({tag, "_count"}, 32'(acc.size() - base), BL);
    if (acc.size() - base >= BL) begin
      for (int i = 0; i < BL; i++) begin
        idx = expBase + 8'(i);
        check($sformatf("%s_data%0d", tag, i), 32'(acc[base + i]), 32'(fifoMem[idx]));
        check($sformatf("%s_last%0d", tag, i), 32'(accLast[base + i]), 32'(i == BL - 1));
      end
    end
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_fifoReadEn"}, 32'(fifoReadEn), 32'd0);
    check({tag, "_outValid"}, 32'(outValid), 32'd0);
    check({tag, "_outData"}, 32'(outData), 32'd0);
    check({tag, "_outLast"}, 32'(outLast), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int base;
    int popBase;
    int startCyc;
    int n;
    logic [7:0] expBase;

    rst = 1'b1; start = 1'b0; outReady = 1'b0; start1 = 1'b0;

    // 1: reset held with random inputs
    repeat (2) begin
      tick();
      start = 1'($urandom); outReady = 1'($urandom); start1 = 1'($urandom);
      checkOutputsZero("reset");
    end
    tick();
    rst = 1'b0; start = 1'b0; start1 = 1'b0;

    // 2: preloaded 0x00..0x0F, full throughput
    for (int i = 0; i < BL; i++) push(8'(i));
    base = acc.size(); popBase = totalPops; expBase = rdIdx;
    outReady = 1'b1;
    pulseStart(startCyc);
    waitDone(100, 0, "t2");
    checkBurst(base, expBase, "t2");
    check("t2_pops", totalPops - popBase, BL);
    if (acc.size() - base >= BL) begin
      check("t2_firstLatency", accCyc[base] - startCyc, 3);
      check("t2_contiguous", accCyc[base + BL - 1] - accCyc[base], BL - 1);
    end
    tick();
    check("t2_busyAfter", 32'(busy), 32'd0);
    check("t2_doneOnce", 32'(done), 32'd0);

    // 3: alternating outReady
    for (int i = 0; i < BL; i++) push(8'($urandom));
    base = acc.size(); popBase = totalPops; expBase = rdIdx;
    outReady = 1'b1;
    pulseStart(startCyc);
    waitDone(200, 1, "t3");
    checkBurst(base, expBase, "t3");
    check("t3_pops", totalPops - popBase, BL);
    tick();

    // 4: FIFO underflow mid-burst
    for (int i = 0; i < 3; i++) push(8'($urandom));
    base = acc.size(); popBase = totalPops; expBase = rdIdx;
    outReady = 1'b1;
    pulseStart(startCyc);
    repeat (12) tick();
    check("t4_partialCount", acc.size() - base, 3);
    check("t4_partialPops", totalPops - popBase, 3);
    check("t4_stillBusy", 32'(busy), 32'd1);
    for (int i = 0; i < BL - 3; i++) begin
      push(8'($urandom));
      tick();
    end
    waitDone(100, 0, "t4");
    checkBurst(base, expBase, "t4");
    check("t4_pops", totalPops - popBase, BL);
    tick();

    // 5: start during RUN and DONE ignored; random backpressure
    for (int i = 0; i < BL + 4; i++) push(8'($urandom));
    base = acc.size(); popBase = totalPops; expBase = rdIdx;
    outReady = 1'b1;
    pulseStart(startCyc);
    repeat (4) tick();
    pulseStart(n);
    waitDone(300, 2, "t5");
    start = 1'b1;
    tick();
    start = 1'b0;
    outReady = 1'b1;
    repeat (8) tick();
    checkBurst(base, expBase, "t5");
    check("t5_noExtraPops", totalPops - popBase, BL);
    check("t5_idleAfter", 32'(busy), 32'd0);

    // 5b: BURST_LEN=1 instance
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 0;
    while (!valid1 && n < 10) begin
      tick();
      n++;
    end
    check("b1_valid", 32'(valid1), 32'd1);
    check("b1_data", 32'(outData1), 32'h5A);
    check("b1_last", 32'(last1), 32'd1);
    tick();
    check("b1_done", 32'(done1), 32'd1);
    repeat (4) tick();
    check("b1_pops", pops1, 1);
    check("b1_idle", 32'(busy1), 32'd0);

    // 6: reset mid-burst, then a fresh burst from the next FIFO words
    for (int i = 0; i < 24; i++) push(8'($urandom));
    base = acc.size();
    outReady = 1'b1;
    pulseStart(startCyc);
    n = 0;
    while (acc.size() - base < 5 && n < 50) begin
      tick();
      n++;
    end
    check("t6_fiveAccepted", acc.size() - base, 5);
    rst = 1'b1;
    tick();
    checkOutputsZero("t6_reset");
    rst = 1'b0;
    base = acc.size(); popBase = totalPops; expBase = rdIdx;
    pulseStart(startCyc);
    waitDone(100, 0, "t6");
    checkBurst(base, expBase, "t6");
    check("t6_pops", totalPops - popBase, BL);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
